// File: rtl/mem_pkg.sv
// Shared definitions for the memory / write-back stage: FSM encoding, default widths, NZCV bit positions.
package mem_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 8;
  localparam int REG_AW_DEF = 3;

  localparam int NZCV_N = 3;
  localparam int NZCV_Z = 2;
  localparam int NZCV_C = 1;
  localparam int NZCV_V = 0;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;
endpackage

// File: rtl/mem_wb_stage_if.sv
// Data-memory req/ack bus; the stage is master, the memory is slave.
interface mem_wb_stage_if #(
  parameter int ADDR_W = mem_pkg::ADDR_W_DEF,
  parameter int DATA_W = mem_pkg::DATA_W_DEF
);
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/mem_access_fsm.sv
// IDLE/ACCESS sequencer: latches the access on entry, holds req until ack, decodes stall/capture/bubble.
// Optional MEM_TIMEOUT_EN aborts an access after TIMEOUT_CYCLES ACCESS cycles and raises sticky mem_err.
module mem_access_fsm
  import mem_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_rd,
  input  logic              mem_wt,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] store_data,
  input  logic              dmem_ack,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic              mem_stall,
  output logic              capture,
  output logic              bubble,
  output logic              load_rdata,
  output logic              abort,
  output logic              mem_err
);

  state_e state, state_nxt;
  logic   mem_op;
  logic   launch;
  logic   timeout;

  assign mem_op   = mem_rd | mem_wt;
  assign dmem_req = (state == ST_ACCESS);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (mem_op) state_nxt = ST_ACCESS;
      ST_ACCESS: if (dmem_ack || timeout) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Ack has priority over timeout so a late but valid response is never discarded.
  always_comb begin
    launch     = 1'b0;
    capture    = 1'b0;
    bubble     = 1'b0;
    load_rdata = 1'b0;
    abort      = 1'b0;
    mem_stall  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (mem_op) begin
          launch    = 1'b1;
          bubble    = 1'b1;
          mem_stall = 1'b1;
        end else begin
          capture = 1'b1;
        end
      end
      ST_ACCESS: begin
        if (dmem_ack) begin
          capture    = 1'b1;
          load_rdata = ~dmem_we;
        end else if (timeout) begin
          capture = 1'b1;
          abort   = 1'b1;
        end else begin
          bubble    = 1'b1;
          mem_stall = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // A simultaneous read+write request resolves to a write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
    end else if (launch) begin
      dmem_we    <= mem_wt;
      dmem_addr  <= mem_addr;
      dmem_wdata <= store_data;
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] to_cnt;
  logic             err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                to_cnt <= '0;
    else if (launch)                           to_cnt <= '0;
    else if (state == ST_ACCESS && !dmem_ack)  to_cnt <= to_cnt + CNT_W'(1);
  end

  assign timeout = (state == ST_ACCESS) && (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     err_q <= 1'b0;
    else if (abort) err_q <= 1'b1;
  end

  assign mem_err = err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout            = 1'b0;
  assign mem_err            = 1'b0;
`endif

endmodule

// File: rtl/mem_wb_stage.sv
// Memory stage + MEM/WB register: 1-cycle latency for ALU ops, memory ops stall upstream until ack.
// Optional MEM_TIMEOUT_EN: bounded ACCESS wait with sticky mem_err on abort.
module mem_wb_stage
  import mem_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int REG_AW         = REG_AW_DEF,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       ex_aluOut,
  input  logic [ADDR_W-1:0] ex_memAddr,
  input  logic [DATA_W-1:0] ex_storeData,
  input  logic              ex_memRd,
  input  logic              ex_memWt,
  input  logic [REG_AW-1:0] ex_rd1,
  input  logic [REG_AW-1:0] ex_rd2,
  input  logic              ex_regWrite1,
  input  logic              ex_regWrite2,
  input  logic [3:0]        ex_nzcv,
  output logic              mem_stall,
  mem_wb_stage_if.master    dmem,
  output logic              wb_valid,
  output logic [31:0]       wb_aluOut,
  output logic [DATA_W-1:0] wb_memData,
  output logic [REG_AW-1:0] wb_rd1,
  output logic [REG_AW-1:0] wb_rd2,
  output logic              wb_regWrite1,
  output logic              wb_regWrite2,
  output logic [3:0]        wb_nzcv,
  output logic              mem_err
);

  logic capture, bubble, load_rdata, abort;

  mem_access_fsm #(
    .ADDR_W         (ADDR_W),
    .DATA_W         (DATA_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_fsm (
    .clk        (clk),
    .reset      (reset),
    .mem_rd     (ex_memRd),
    .mem_wt     (ex_memWt),
    .mem_addr   (ex_memAddr),
    .store_data (ex_storeData),
    .dmem_ack   (dmem.dmem_ack),
    .dmem_req   (dmem.dmem_req),
    .dmem_we    (dmem.dmem_we),
    .dmem_addr  (dmem.dmem_addr),
    .dmem_wdata (dmem.dmem_wdata),
    .mem_stall  (mem_stall),
    .capture    (capture),
    .bubble     (bubble),
    .load_rdata (load_rdata),
    .abort      (abort),
    .mem_err    (mem_err)
  );

  // Upstream is frozen while ACCESS waits, so ex_* still describe the in-flight instruction at ack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_valid     <= 1'b0;
      wb_aluOut    <= '0;
      wb_memData   <= '0;
      wb_rd1       <= '0;
      wb_rd2       <= '0;
      wb_regWrite1 <= 1'b0;
      wb_regWrite2 <= 1'b0;
      wb_nzcv      <= '0;
    end else if (capture) begin
      wb_valid     <= 1'b1;
      wb_aluOut    <= ex_aluOut;
      wb_rd1       <= ex_rd1;
      wb_rd2       <= ex_rd2;
      wb_regWrite1 <= ex_regWrite1 & ~abort;
      wb_regWrite2 <= ex_regWrite2 & ~abort;
      wb_nzcv      <= {ex_nzcv[NZCV_N], ex_nzcv[NZCV_Z], ex_nzcv[NZCV_C], ex_nzcv[NZCV_V]};
      if (load_rdata) wb_memData <= dmem.dmem_rdata;
    end else if (bubble) begin
      wb_valid     <= 1'b0;
      wb_regWrite1 <= 1'b0;
      wb_regWrite2 <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized bench for mem_wb_stage; expected stall lengths and WB contents come from a transaction-level model.
module tb_mem_wb_stage;
  import mem_pkg::*;

  localparam int TO = 4;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] addr;
    logic [7:0]  sd;
    logic        rd;
    logic        wt;
    logic [2:0]  r1;
    logic [2:0]  r2;
    logic        w1;
    logic        w2;
    logic [3:0]  f;
  } instr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] ex_aluOut;
  logic [31:0] ex_memAddr;
  logic [7:0]  ex_storeData;
  logic        ex_memRd, ex_memWt;
  logic [2:0]  ex_rd1, ex_rd2;
  logic        ex_regWrite1, ex_regWrite2;
  logic [3:0]  ex_nzcv;
  logic        mem_stall;
  logic        wb_valid;
  logic [31:0] wb_aluOut;
  logic [7:0]  wb_memData;
  logic [2:0]  wb_rd1, wb_rd2;
  logic        wb_regWrite1, wb_regWrite2;
  logic [3:0]  wb_nzcv;
  logic        mem_err;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] m_memdata;
  logic       m_err;

  always #5 clk = ~clk;

  mem_wb_stage_if #(.ADDR_W(32), .DATA_W(8)) dif ();

  mem_wb_stage #(
    .ADDR_W(32), .DATA_W(8), .REG_AW(3), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .ex_aluOut(ex_aluOut), .ex_memAddr(ex_memAddr), .ex_storeData(ex_storeData),
    .ex_memRd(ex_memRd), .ex_memWt(ex_memWt),
    .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
    .ex_regWrite1(ex_regWrite1), .ex_regWrite2(ex_regWrite2),
    .ex_nzcv(ex_nzcv), .mem_stall(mem_stall), .dmem(dif),
    .wb_valid(wb_valid), .wb_aluOut(wb_aluOut), .wb_memData(wb_memData),
    .wb_rd1(wb_rd1), .wb_rd2(wb_rd2),
    .wb_regWrite1(wb_regWrite1), .wb_regWrite2(wb_regWrite2),
    .wb_nzcv(wb_nzcv), .mem_err(mem_err)
  );

  function automatic instr_t rand_instr(input int kind);
    instr_t i;
    i.alu  = $urandom;
    i.addr = $urandom;
    i.sd   = 8'($urandom);
    i.rd   = (kind == 1) || (kind == 3);
    i.wt   = (kind >= 2);
    i.r1   = 3'($urandom);
    i.r2   = 3'($urandom);
    i.w1   = 1'($urandom);
    i.w2   = 1'($urandom);
    i.f    = 4'($urandom);
    return i;
  endfunction

  task automatic drive(input instr_t i);
    ex_aluOut    = i.alu;
    ex_memAddr   = i.addr;
    ex_storeData = i.sd;
    ex_memRd     = i.rd;
    ex_memWt     = i.wt;
    ex_rd1       = i.r1;
    ex_rd2       = i.r2;
    ex_regWrite1 = i.w1;
    ex_regWrite2 = i.w2;
    ex_nzcv      = i.f;
  endtask

  // Called at posedge+1; delay = ACCESS cycles before ack (negative: never acked).
  task automatic run_instr(input instr_t i, input int delay, input logic [7:0] rdata, input string tag);
    int   stalls, exp_stalls;
    logic memop, aborted;
    memop   = i.rd | i.wt;
    stalls  = 0;
    aborted = 1'b0;
`ifdef MEM_TIMEOUT_EN
    aborted = memop && (delay < 0 || delay > TO - 1);
`endif
    exp_stalls = !memop ? 0 : (aborted ? TO : delay + 1);
    drive(i);
    @(negedge clk);
    tests_run++;
    if ({mem_stall, dif.dmem_req} !== {memop, 1'b0}) begin
      tests_failed++;
      $display("FAIL %s idle_stall_req got %b want %b", tag, {mem_stall, dif.dmem_req}, {memop, 1'b0});
    end
    if (mem_stall) stalls++;
    if (memop) begin
      for (int k = 0; k < 64; k++) begin
        @(posedge clk); #1;
        tests_run++;
        if ({dif.dmem_req, dif.dmem_we, dif.dmem_addr, dif.dmem_wdata, wb_valid, wb_regWrite1, wb_regWrite2}
            !== {1'b1, i.wt, i.addr, i.sd, 3'b000}) begin
          tests_failed++;
          $display("FAIL %s access_bus k=%0d got req=%b we=%b addr=%h wd=%h v=%b w=%b%b want req=1 we=%b addr=%h wd=%h v=0 w=00",
                   tag, k, dif.dmem_req, dif.dmem_we, dif.dmem_addr, dif.dmem_wdata, wb_valid,
                   wb_regWrite1, wb_regWrite2, i.wt, i.addr, i.sd);
        end
        if (k == delay) begin
          dif.dmem_ack   = 1'b1;
          dif.dmem_rdata = rdata;
        end else begin
          dif.dmem_rdata = 8'($urandom);
        end
        @(negedge clk);
        if (!mem_stall) break;
        stalls++;
        if (k == 63) begin
          tests_run++;
          tests_failed++;
          $display("FAIL %s access_timeout stall still high after 64 cycles", tag);
        end
      end
    end
    @(posedge clk); #1;
    dif.dmem_ack = 1'b0;
    if (memop && !aborted && !i.wt) m_memdata = rdata;
    if (aborted) m_err = 1'b1;
    tests_run++;
    if (stalls !== exp_stalls) begin
      tests_failed++;
      $display("FAIL %s stall_cycles got %0d want %0d", tag, stalls, exp_stalls);
    end
    tests_run++;
    if ({wb_valid, wb_aluOut, wb_memData, wb_rd1, wb_rd2, wb_regWrite1, wb_regWrite2, wb_nzcv, mem_err, dif.dmem_req}
        !== {1'b1, i.alu, m_memdata, i.r1, i.r2, i.w1 & ~aborted, i.w2 & ~aborted, i.f, m_err, 1'b0}) begin
      tests_failed++;
      $display("FAIL %s wb got v=%b alu=%h md=%h rd=%0d/%0d w=%b%b f=%h err=%b req=%b want v=1 alu=%h md=%h rd=%0d/%0d w=%b%b f=%h err=%b req=0",
               tag, wb_valid, wb_aluOut, wb_memData, wb_rd1, wb_rd2, wb_regWrite1, wb_regWrite2, wb_nzcv,
               mem_err, dif.dmem_req, i.alu, m_memdata, i.r1, i.r2, i.w1 & ~aborted, i.w2 & ~aborted, i.f, m_err);
    end
  endtask

  task automatic test_reset();
    drive(rand_instr(0));
    dif.dmem_ack   = 1'b0;
    dif.dmem_rdata = 8'h00;
    reset          = 1'b0;
    m_memdata      = 8'h00;
    m_err          = 1'b0;
    #12;
    tests_run++;
    if ({wb_valid, wb_aluOut, wb_memData, wb_rd1, wb_rd2, wb_regWrite1, wb_regWrite2, wb_nzcv, mem_err,
         dif.dmem_req, dif.dmem_we, dif.dmem_addr, dif.dmem_wdata} !== '0) begin
      tests_failed++;
      $display("FAIL reset_state got v=%b alu=%h md=%h err=%b req=%b we=%b addr=%h wd=%h want all zero",
               wb_valid, wb_aluOut, wb_memData, mem_err, dif.dmem_req, dif.dmem_we, dif.dmem_addr, dif.dmem_wdata);
    end
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_alu();
    instr_t i;
    i     = rand_instr(0);
    i.alu = 32'h0000_00A5;
    i.r1  = 3'd3;
    i.w1  = 1'b1;
    run_instr(i, 0, 8'h00, "alu_a5");
    for (int n = 0; n < 4; n++) run_instr(rand_instr(0), 0, 8'h00, "alu_rand");
  endtask

  task automatic test_load();
    instr_t i;
    i      = rand_instr(1);
    i.addr = 32'h10;
    run_instr(i, 3, 8'h5C, "load_5c");
    run_instr(rand_instr(1), 1, 8'($urandom), "load_rand");
  endtask

  task automatic test_store();
    instr_t i;
    i    = rand_instr(2);
    i.sd = 8'h3E;
    run_instr(i, 0, 8'($urandom), "store_3e");
    run_instr(rand_instr(3), 0, 8'($urandom), "store_rdwt");
    run_instr(rand_instr(3), 2, 8'($urandom), "store_rdwt_wait");
  endtask

  task automatic test_ack_idle();
    dif.dmem_ack   = 1'b1;
    dif.dmem_rdata = 8'($urandom);
    run_instr(rand_instr(0), 0, 8'h00, "ack_in_idle");
  endtask

  task automatic test_ack_at_expiry();
    run_instr(rand_instr(1), TO - 1, 8'($urandom), "ack_at_expiry_load");
    run_instr(rand_instr(2), TO - 1, 8'($urandom), "ack_at_expiry_store");
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 30; n++)
      run_instr(rand_instr(int'($urandom_range(0, 3))), int'($urandom_range(0, TO - 1)),
                8'($urandom), "back_to_back");
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    run_instr(rand_instr(1), -1, 8'($urandom), "timeout_load");
    run_instr(rand_instr(0), 0, 8'h00, "after_timeout_alu");
    run_instr(rand_instr(2), -1, 8'($urandom), "timeout_store");
    run_instr(rand_instr(1), 1, 8'($urandom), "after_timeout_load");
  endtask
`endif

  task automatic test_reset_access();
    drive(rand_instr(1));
    @(negedge clk);
    @(posedge clk); #1;
    tests_run++;
    if (dif.dmem_req !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_access_req_before got %b want 1", dif.dmem_req);
    end
    #2 reset = 1'b0;
    #1;
    m_memdata = 8'h00;
    m_err     = 1'b0;
    tests_run++;
    if ({dif.dmem_req, wb_valid, mem_err} !== 3'b000) begin
      tests_failed++;
      $display("FAIL rst_access_during got req/valid/err=%b want 000", {dif.dmem_req, wb_valid, mem_err});
    end
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    tests_run++;
    if ({dif.dmem_req, wb_valid, mem_stall} !== 3'b001) begin
      tests_failed++;
      $display("FAIL rst_access_after got req/valid/stall=%b want 001", {dif.dmem_req, wb_valid, mem_stall});
    end
    run_instr(rand_instr(0), 0, 8'h00, "rst_access_next_alu");
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_ack_idle();
    test_ack_at_expiry();
    test_back_to_back();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_access();
    test_alu();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
